// File: rtl/npu_host_seq.sv
// Host-side bus initiator for the NPU slave port: turns WRITE/READ/POLL commands
// into single-beat ena/wea transactions and returns one response per command.
module npu_host_seq #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 32,
    parameter int POLL_TIMEOUT = 1024,
    parameter int POLL_GAP     = 2
) (
    input  logic              clk,
    input  logic              rst_ni,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              ena,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    input  logic [DATA_W-1:0] douta,
    output logic              busy
);

    localparam int CNT_W = $clog2(POLL_TIMEOUT + 1);
    localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(POLL_TIMEOUT);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((POLL_GAP > 0) ? POLL_GAP - 1 : 0);
    localparam logic [1:0] OP_WR   = 2'd0;
    localparam logic [1:0] OP_RD   = 2'd1;
    localparam logic [1:0] OP_POLL = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_REQ, S_RD_CAP, S_GAP, S_RSP} state_t;

    state_t            state, state_nx;
    logic [1:0]        op_q, op_nx;
    logic [ADDR_W-1:0] addr_q, addr_nx;
    logic [DATA_W-1:0] data_q, data_nx;
    logic [CNT_W-1:0]  cnt_q, cnt_nx;
    logic [GAP_W-1:0]  gap_q, gap_nx;
    logic              ena_nx, wea_nx, rsp_valid_nx, rsp_err_nx;
    logic [ADDR_W-1:0] addra_nx;
    logic [DATA_W-1:0] dina_nx, rsp_data_nx;

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= S_IDLE;
            cnt_q     <= '0;
            gap_q     <= '0;
            ena       <= 1'b0;
            wea       <= 1'b0;
            addra     <= '0;
            dina      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt_q     <= cnt_nx;
            gap_q     <= gap_nx;
            ena       <= ena_nx;
            wea       <= wea_nx;
            addra     <= addra_nx;
            dina      <= dina_nx;
            rsp_valid <= rsp_valid_nx;
            rsp_data  <= rsp_data_nx;
            rsp_err   <= rsp_err_nx;
        end
    end

    // Latched command copy; only meaningful while busy, so it needs no reset.
    always_ff @(posedge clk) begin
        op_q   <= op_nx;
        addr_q <= addr_nx;
        data_q <= data_nx;
    end

    always_comb begin
        state_nx     = state;
        op_nx        = op_q;
        addr_nx      = addr_q;
        data_nx      = data_q;
        cnt_nx       = cnt_q;
        gap_nx       = gap_q;
        ena_nx       = 1'b0;
        wea_nx       = 1'b0;
        addra_nx     = '0;
        dina_nx      = '0;
        rsp_valid_nx = rsp_valid;
        rsp_data_nx  = rsp_data;
        rsp_err_nx   = rsp_err;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_nx       = cmd_op;
                    addr_nx     = cmd_addr;
                    data_nx     = cmd_data;
                    cnt_nx      = '0;
                    rsp_data_nx = '0;
                    rsp_err_nx  = 1'b0;
                    case (cmd_op)
                        OP_WR: begin
                            state_nx = S_WR;
                            ena_nx   = 1'b1;
                            wea_nx   = 1'b1;
                            addra_nx = cmd_addr;
                            dina_nx  = cmd_data;
                        end
                        OP_RD, OP_POLL: begin
                            state_nx = S_RD_REQ;
                            ena_nx   = 1'b1;
                            addra_nx = cmd_addr;
                        end
                        default: begin
                            state_nx     = S_RSP;
                            rsp_valid_nx = 1'b1;
                            rsp_err_nx   = 1'b1;
                        end
                    endcase
                end
            end
            S_WR: begin
                state_nx     = S_RSP;
                rsp_valid_nx = 1'b1;
            end
            S_RD_REQ: begin
                // Counter never exceeds CNT_MAX: timeout is checked before every re-read.
                cnt_nx   = cnt_q + CNT_W'(1);
                state_nx = S_RD_CAP;
            end
            S_RD_CAP: begin
                rsp_data_nx = douta;
                if (op_q == OP_RD || (douta & data_q) != '0) begin
                    state_nx     = S_RSP;
                    rsp_valid_nx = 1'b1;
                end else if (cnt_q == CNT_MAX) begin
                    state_nx     = S_RSP;
                    rsp_valid_nx = 1'b1;
                    rsp_err_nx   = 1'b1;
                end else if (POLL_GAP == 0) begin
                    state_nx = S_RD_REQ;
                    ena_nx   = 1'b1;
                    addra_nx = addr_q;
                end else begin
                    state_nx = S_GAP;
                    gap_nx   = '0;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_nx = S_RD_REQ;
                    ena_nx   = 1'b1;
                    addra_nx = addr_q;
                end else begin
                    gap_nx = gap_q + GAP_W'(1);
                end
            end
            S_RSP: begin
                if (rsp_ready) begin
                    state_nx     = S_IDLE;
                    rsp_valid_nx = 1'b0;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_npu_host_seq.sv
// Self-checking bench for npu_host_seq: directed scenarios plus randomized commands
// against a transaction-level model of the bus sequencing and a scripted slave.
module tb_npu_host_seq;

    localparam int TO  = 4;
    localparam int GAP = 2;
    localparam logic [15:0] STAT = 16'h7000;

    logic        clk = 1'b0, rst_ni = 1'b0, cmd_valid = 1'b0, rsp_ready = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic [15:0] cmd_addr = '0;
    logic [31:0] cmd_data = '0, douta = '0;
    logic        cmd_ready, rsp_valid, rsp_err, ena, wea, busy;
    logic [15:0] addra;
    logic [31:0] rsp_data, dina;

    npu_host_seq #(.ADDR_W(16), .DATA_W(32), .POLL_TIMEOUT(TO), .POLL_GAP(GAP)) dut (
        .clk(clk), .rst_ni(rst_ni), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          c;
        logic        w;
        logic [15:0] a;
        logic [31:0] d;
    } beat_t;

    int          n_chk = 0, n_fail = 0, cyc = 0, rd_cnt = 0, poll_hit = 0;
    beat_t       beat_log[$];
    logic [31:0] s_mem[256], r_mem[256];
    bit          s_wr[256], r_wr[256];
    logic [31:0] hit_val = '0, miss_val = '0;
    bit          prev_ena = 1'b0, b2b = 1'b0;

    function automatic logic [31:0] init_val(logic [15:0] a);
        return {a ^ 16'hA5C3, ~a};
    endfunction

    // Status register script: the k-th status read of a command returns hit_val when k == poll_hit.
    function automatic logic [31:0] status_val(int k);
        return (k == poll_hit) ? hit_val : miss_val;
    endfunction

    function automatic logic [31:0] model_rd(logic [15:0] a, int k);
        if (a == STAT) return status_val(k);
        return r_wr[a[7:0]] ? r_mem[a[7:0]] : init_val(a);
    endfunction

    // Slave port model and bus monitor; a beat seen before edge n belongs to cycle cyc+1.
    always @(posedge clk) begin
        cyc      <= cyc + 1;
        prev_ena <= ena;
        if (ena && prev_ena) b2b <= 1'b1;
        if (ena) beat_log.push_back(beat_t'{cyc + 1, wea, addra, dina});
        if (cmd_valid && cmd_ready) rd_cnt <= 0;
        if (ena && wea) begin
            s_mem[addra[7:0]] <= dina;
            s_wr[addra[7:0]]  <= 1'b1;
        end
        if (ena && !wea) begin
            if (addra == STAT) begin
                douta  <= status_val(rd_cnt + 1);
                rd_cnt <= rd_cnt + 1;
            end else begin
                douta <= s_wr[addra[7:0]] ? s_mem[addra[7:0]] : init_val(addra);
            end
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic [15:0] a, input logic [31:0] d,
                           input int hold, output int lat, output logic [31:0] data_o);
        int          t0, k, base, exp_lat, n_rd;
        logic [31:0] exp_d, v;
        logic        exp_e;
        beat_t       exp_b[$];
        exp_d   = '0;
        exp_e   = 1'b0;
        exp_lat = 1;
        case (op)
            2'd0: begin exp_b.push_back(beat_t'{1, 1'b1, a, d}); exp_lat = 2; end
            2'd1: begin exp_b.push_back(beat_t'{1, 1'b0, a, 32'h0}); exp_lat = 3; exp_d = model_rd(a, 1); end
            2'd2: begin
                n_rd  = 0;
                exp_e = 1'b1;
                for (int i = 1; i <= TO; i++) begin
                    v = model_rd(a, i);
                    exp_b.push_back(beat_t'{1 + (i - 1) * (GAP + 2), 1'b0, a, 32'h0});
                    n_rd  = i;
                    exp_d = v;
                    if ((v & d) != 0) begin
                        exp_e = 1'b0;
                        break;
                    end
                end
                exp_lat = 3 + (n_rd - 1) * (GAP + 2);
            end
            default: begin exp_lat = 1; exp_e = 1'b1; end
        endcase
        base      = beat_log.size();
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        chk("cmd_ready_idle", 96'(cmd_ready), 96'd1);
        @(posedge clk); #1;
        t0 = cyc;
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom);
        cmd_addr  = 16'($urandom);
        cmd_data  = $urandom;
        k = 1;
        while (rsp_valid !== 1'b1 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        lat    = k;
        data_o = rsp_data;
        chk("rsp_seen", 96'(rsp_valid), 96'd1);
        chk("latency", 96'(k), 96'(exp_lat));
        chk("rsp_data", 96'(rsp_data), 96'(exp_d));
        chk("rsp_err", 96'(rsp_err), 96'(exp_e));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            chk("rsp_hold", 96'({rsp_valid, rsp_err, cmd_ready, rsp_data}), 96'({1'b1, exp_e, 1'b0, exp_d}));
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_release", 96'({rsp_valid, cmd_ready}), 96'(2'b01));
        chk("beat_count", 96'(beat_log.size() - base), 96'(exp_b.size()));
        for (int i = 0; i < exp_b.size() && base + i < beat_log.size(); i++)
            chk("beat", 96'({16'(beat_log[base + i].c - t0), beat_log[base + i].w, beat_log[base + i].a, beat_log[base + i].d}),
                96'({16'(exp_b[i].c), exp_b[i].w, exp_b[i].a, exp_b[i].d}));
        if (op == 2'd0) begin
            r_mem[a[7:0]] = d;
            r_wr[a[7:0]]  = 1'b1;
        end
    endtask

    initial begin
        int          lat;
        logic [31:0] dv, mask, d;
        logic [1:0]  op;
        logic [15:0] a;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 96'({ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy, cmd_ready}), 96'd1);
        rst_ni = 1'b1;
        @(posedge clk); #1;

        run_cmd(2'd0, 16'h2000, 32'h04030201, 0, lat, dv);
        chk("t1_latency", 96'(lat), 96'd2);
        run_cmd(2'd0, 16'h7004, 32'hFFFFFF85, 0, lat, dv);
        run_cmd(2'd1, 16'h7004, 32'h0, 0, lat, dv);
        chk("t2_data", 96'(dv), 96'(32'hFFFFFF85));
        chk("t2_latency", 96'(lat), 96'd3);

        poll_hit = 3; hit_val = 32'h1; miss_val = 32'h0;
        run_cmd(2'd2, STAT, 32'h1, 0, lat, dv);
        chk("t3_latency", 96'(lat), 96'd11);
        chk("t3_data", 96'(dv), 96'd1);

        poll_hit = 0; miss_val = 32'h0;
        run_cmd(2'd2, STAT, 32'hFFFFFFFF, 0, lat, dv);
        chk("t4_data", 96'(dv), 96'd0);

        run_cmd(2'd1, 16'h2000, 32'h0, 5, lat, dv);
        chk("t5_data", 96'(dv), 96'(32'h04030201));

        repeat (40) begin
            op   = 2'($urandom_range(0, 3));
            a    = ($urandom_range(0, 2) == 0) ? STAT : 16'($urandom);
            mask = $urandom;
            if (mask == 0) mask = 32'h1;
            poll_hit = $urandom_range(0, TO);
            hit_val  = $urandom | (mask & -mask);
            miss_val = $urandom & ~mask;
            d = (op == 2'd2) ? mask : $urandom;
            run_cmd(op, a, d, $urandom_range(0, 3), lat, dv);
        end

        poll_hit = 0; miss_val = 32'h0;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = STAT; cmd_data = 32'h1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        chk("t6_in_gap", 96'({busy, ena}), 96'(2'b10));
        rst_ni = 1'b0;
        #1;
        chk("t6_async_reset", 96'({ena, wea, addra, dina, rsp_valid, rsp_data, rsp_err, busy}), 96'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
        chk("t6_no_rsp", 96'({rsp_valid, cmd_ready, busy}), 96'(3'b010));
        run_cmd(2'd0, 16'h1234, 32'hCAFEF00D, 0, lat, dv);
        chk("t6_write_latency", 96'(lat), 96'd2);

        chk("no_back_to_back_ena", 96'(b2b), 96'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
